// File: rtl/fully_connected.sv
// fully_connected: output dense layer of the MNIST CNN datapath.
// Computes OUT_NUM fixed-point logits (bias + sum of x*w) with one MAC per
// clock and writes them sequentially into the SoftMax input buffer.
// Optional feature macro: FULLY_CONNECTED_SATURATE_EN
//   defined   -> results outside the DATA_WIDTH signed range clamp
//   undefined -> results wrap (low DATA_WIDTH bits kept)
module fully_connected #(
  parameter int DATA_WIDTH    = 32,
  parameter int FRACTION_BITS = 20,
  parameter int IN_NUM        = 64,
  parameter int IN_ADR_WIDTH  = 6,
  parameter int OUT_NUM       = 10,
  parameter int OUT_ADR_WIDTH = 4,
  parameter int W_ADR_WIDTH   = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     axisif_in_start,
  output logic                     axisif_out_done,
  output logic [IN_ADR_WIDTH-1:0]  out_adrIn,
  input  logic [DATA_WIDTH-1:0]    in_dataIn,
  output logic [W_ADR_WIDTH-1:0]   out_adrW,
  input  logic [DATA_WIDTH-1:0]    in_dataW,
  output logic [OUT_ADR_WIDTH-1:0] out_adrB,
  input  logic [DATA_WIDTH-1:0]    in_dataB,
  output logic [OUT_ADR_WIDTH-1:0] out_adrOut,
  output logic [DATA_WIDTH-1:0]    out_dataOut,
  output logic                     out_wr
);

  localparam int ACC_W = 2*DATA_WIDTH + 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BIAS  = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [IN_ADR_WIDTH-1:0]  LAST_I = IN_ADR_WIDTH'(IN_NUM - 1);
  localparam logic [OUT_ADR_WIDTH-1:0] LAST_O = OUT_ADR_WIDTH'(OUT_NUM - 1);

`ifdef FULLY_CONNECTED_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  logic [2:0]                r_state;
  logic [OUT_ADR_WIDTH-1:0]  r_o;
  logic [IN_ADR_WIDTH-1:0]   r_i;
  logic [W_ADR_WIDTH-1:0]    r_adrW;
  logic signed [ACC_W-1:0]   r_acc;
  logic [DATA_WIDTH-1:0]     r_dataOut;
  logic [OUT_ADR_WIDTH-1:0]  r_adrOut;

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0]        w_prod_ext;
  logic signed [ACC_W-1:0]        w_bias_ext;
  logic signed [ACC_W-1:0]        w_acc_sum;

  // Drop the fraction (floor) and fit the result into DATA_WIDTH bits.
  function automatic logic [DATA_WIDTH-1:0] reduce_result(
    input logic signed [ACC_W-1:0] acc
  );
`ifdef FULLY_CONNECTED_SATURATE_EN
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRACTION_BITS;
    if (sh > SAT_MAX)
      reduce_result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (sh < SAT_MIN)
      reduce_result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      reduce_result = DATA_WIDTH'(sh);
`else
    reduce_result = DATA_WIDTH'(acc >>> FRACTION_BITS);
`endif
  endfunction

  assign w_prod     = $signed(in_dataIn) * $signed(in_dataW);
  assign w_prod_ext = {{(ACC_W-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
  // Bias is pre-scaled by 2^FRACTION_BITS so it sits at product scale.
  assign w_bias_ext = $signed({{(ACC_W-DATA_WIDTH){in_dataB[DATA_WIDTH-1]}}, in_dataB})
                      <<< FRACTION_BITS;
  assign w_acc_sum  = r_acc + w_prod_ext;

  // Addresses are only driven in the state that uses them, zero otherwise.
  assign out_adrIn       = (r_state == S_MAC)  ? r_i    : '0;
  assign out_adrW        = (r_state == S_MAC)  ? r_adrW : '0;
  assign out_adrB        = (r_state == S_BIAS) ? r_o    : '0;
  assign out_wr          = (r_state == S_WRITE);
  assign axisif_out_done = (r_state == S_DONE);
  assign out_adrOut      = r_adrOut;
  assign out_dataOut     = r_dataOut;

  // Control FSM, counters and the held output word/address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_o       <= '0;
      r_i       <= '0;
      r_adrW    <= '0;
      r_dataOut <= '0;
      r_adrOut  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (axisif_in_start) begin
            r_o     <= '0;
            r_i     <= '0;
            r_adrW  <= '0;
            r_state <= S_BIAS;
          end
        end
        S_BIAS: r_state <= S_MAC;
        S_MAC: begin
          r_i    <= r_i + 1'b1;
          // Running weight address replaces the o*IN_NUM+i multiply.
          r_adrW <= r_adrW + 1'b1;
          if (r_i == LAST_I) begin
            // Latch the finished result so it is stable through WRITE.
            r_dataOut <= reduce_result(w_acc_sum);
            r_adrOut  <= r_o;
            r_state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_o == LAST_O) begin
            r_state <= S_DONE;
          end else begin
            r_o     <= r_o + 1'b1;
            r_i     <= '0;
            r_state <= S_BIAS;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Accumulator: load scaled bias, then add one product per MAC cycle.
  always_ff @(posedge clk) begin
    if (r_state == S_BIAS)
      r_acc <= w_bias_ext;
    else if (r_state == S_MAC)
      r_acc <= w_acc_sum;
  end

endmodule

// File: tb/tb_fully_connected.sv
// Testbench for fully_connected: directed runs plus random data, checked
// against an arithmetic model of the dense layer.
module tb_fully_connected;

  localparam int DW   = 32;
  localparam int FB   = 20;
  localparam int NIN  = 64;
  localparam int NOUT = 10;
  localparam int NEUR_CYC = NIN + 2;
  localparam int DONE_CYC = NOUT * NEUR_CYC + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [5:0]  adrIn;
  logic [9:0]  adrW;
  logic [3:0]  adrB;
  logic [3:0]  adrOut;
  logic [31:0] dataOut;
  logic        wr;

  logic signed [31:0] xm [NIN];
  logic signed [31:0] wm [NIN*NOUT];
  logic signed [31:0] bm [NOUT];
  logic [31:0]        expv [NOUT];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fully_connected #(
    .DATA_WIDTH(DW), .FRACTION_BITS(FB), .IN_NUM(NIN), .IN_ADR_WIDTH(6),
    .OUT_NUM(NOUT), .OUT_ADR_WIDTH(4), .W_ADR_WIDTH(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .axisif_in_start(start), .axisif_out_done(done),
    .out_adrIn(adrIn), .in_dataIn(xm[adrIn]),
    .out_adrW(adrW), .in_dataW(wm[adrW]),
    .out_adrB(adrB), .in_dataB(bm[adrB]),
    .out_adrOut(adrOut), .out_dataOut(dataOut), .out_wr(wr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Logit o = floor((bias*2^FB + sum x*w) / 2^FB), then fitted to 32 bits.
  function automatic logic [31:0] model(input int o);
    logic signed [127:0] acc, p, q, r;
    acc = bm[o];
    acc = acc * 128'sd1048576;
    for (int i = 0; i < NIN; i++) begin
      p = xm[i];
      q = wm[o*NIN + i];
      acc = acc + p * q;
    end
    r = acc >>> FB;
`ifdef FULLY_CONNECTED_SATURATE_EN
    if (r > 128'sd2147483647)       return 32'h7FFF_FFFF;
    else if (r < -128'sd2147483648) return 32'h8000_0000;
    else                            return r[31:0];
`else
    return r[31:0];
`endif
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < NIN; i++) begin
      case (mode)
        0: xm[i] = 0;
        1: xm[i] = 32'h0010_0000;
        2: xm[i] = -32'sh0020_0000;
        3: xm[i] = 32'sd1000 <<< FB;
        4: xm[i] = $signed($urandom_range(0, 32'h0100_0000)) - 32'sh0080_0000;
        default: xm[i] = $urandom;
      endcase
    end
    for (int k = 0; k < NIN*NOUT; k++) begin
      case (mode)
        0: wm[k] = $urandom;
        1: wm[k] = 32'h0010_0000;
        2: wm[k] = 32'h0008_0000;
        3: wm[k] = 32'sd1000 <<< FB;
        4: wm[k] = $signed($urandom_range(0, 32'h0100_0000)) - 32'sh0080_0000;
        default: wm[k] = $urandom;
      endcase
    end
    for (int o = 0; o < NOUT; o++) begin
      case (mode)
        0: bm[o] = o <<< FB;
        1: bm[o] = 0;
        2: bm[o] = 32'h0010_0000;
        3: bm[o] = 0;
        4: bm[o] = $signed($urandom_range(0, 32'h0400_0000)) - 32'sh0200_0000;
        default: bm[o] = $urandom;
      endcase
    end
    for (int o = 0; o < NOUT; o++) expv[o] = model(o);
  endtask

  // One run: start pulse at E0, then watch cycles 1..700 after E0.
  // rs1/rs2: cycles with extra start pulses; rst_at: cycle of mid-run reset.
  task automatic run(input string nm, input int rs1, input int rs2, input int rst_at);
    int nw, nd, exp_nw, exp_nd;
    nw = 0; nd = 0;
    exp_nw = (rst_at > 0) ? rst_at / NEUR_CYC : NOUT;
    exp_nd = (rst_at > 0) ? 0 : 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      if (wr) begin
        check({nm, ":wr_cycle"}, c, NEUR_CYC * (nw + 1));
        if (nw < NOUT) begin
          check({nm, ":adrOut"}, adrOut, nw);
          check({nm, ":dataOut"}, dataOut, expv[nw]);
        end
        nw++;
      end
      if (done) begin
        check({nm, ":done_cycle"}, c, DONE_CYC);
        nd++;
      end
      if (rst_at > 0 && c == rst_at + 1) begin
        check({nm, ":rst_wr"}, wr, 0);
        check({nm, ":rst_done"}, done, 0);
        check({nm, ":rst_addrs"}, {adrIn, adrW, adrB, adrOut}, 0);
        check({nm, ":rst_data"}, dataOut, 0);
      end
      start = (c == rs1 || c == rs2);
      rst_n = !(rst_at > 0 && c == rst_at);
    end
    check({nm, ":n_writes"}, nw, exp_nw);
    check({nm, ":n_done"}, nd, exp_nd);
    check({nm, ":idle_addrs"}, {adrIn, adrW, adrB, wr}, 0);
  endtask

  initial begin
    int nw;
    fill(1);
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {done, adrIn, adrW, adrB, adrOut, dataOut, wr}, 0);

    // Reset and start at the same edge: stays idle
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    nw = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (wr || done) nw++;
    end
    check("rst_start_idle", nw, 0);

    fill(0); run("zero_x_bias", -1, -1, 0);
    fill(1); run("ones", -1, -1, 0);
    check("ones_value", expv[3], 32'h0400_0000);
    fill(2); run("neg2_half", -1, -1, 0);
    check("neg2_value", expv[7], 32'hFC10_0000);
    fill(3); run("big", -1, -1, 0);
    fill(4); run("midrun_reset", -1, -1, 100);
    run("after_reset", -1, -1, 0);
    fill(4); run("restart_ignored", 5, 300, 0);
    fill(5); run("random_full", -1, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fully_connected.md
# fully_connected

Output dense layer of the MNIST CNN datapath, directly upstream of the SoftMax stage. On a start pulse it reads the flattened feature vector, the weight matrix and the bias vector from external synchronous-write/asynchronous-read memories. It computes OUT_NUM fixed-point logits with one multiply-accumulate per clock and writes them sequentially into the buffer that SoftMax reads. It uses the same start/done pulse handshake as the other layer blocks.

## Interface
- DATA_WIDTH, 32, signed fixed-point word width of inputs, weights, bias and outputs
- FRACTION_BITS, 20, fractional bits of every word (Q11.20 at defaults)
- IN_NUM, 64, input vector length
- IN_ADR_WIDTH, 6, input address width; must satisfy 2^IN_ADR_WIDTH ≥ IN_NUM
- OUT_NUM, 10, number of output neurons
- OUT_ADR_WIDTH, 4, output and bias address width
- W_ADR_WIDTH, 10, weight address width; must satisfy 2^W_ADR_WIDTH ≥ IN_NUM*OUT_NUM
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- axisif_in_start  in  1  one-cycle start pulse
- axisif_out_done  out  1  one-cycle pulse after the last output is written
- out_adrIn  out  IN_ADR_WIDTH  input vector read address
- in_dataIn  in  DATA_WIDTH  input word, combinationally valid for out_adrIn
- out_adrW  out  W_ADR_WIDTH  weight read address, row-major: o*IN_NUM+i
- in_dataW  in  DATA_WIDTH  weight word, combinationally valid for out_adrW
- out_adrB  out  OUT_ADR_WIDTH  bias read address
- in_dataB  in  DATA_WIDTH  bias word, combinationally valid for out_adrB
- out_adrOut  out  OUT_ADR_WIDTH  result write address
- out_dataOut  out  DATA_WIDTH  result data
- out_wr  out  1  result write strobe, one cycle per output

## Operation
- FSM states: IDLE, BIAS, MAC, WRITE, DONE.
- IDLE: all addresses are 0 and out_wr is 0. When axisif_in_start is sampled high, the block clears neuron index o and input index i and goes to BIAS.
- BIAS: presents out_adrB=o. Loads the accumulator with in_dataB sign-extended and shifted left by FRACTION_BITS, which aligns it to the product scale. Goes to MAC.
- MAC: presents out_adrIn=i and out_adrW=o*IN_NUM+i. The weight address comes from a running counter, with no multiplier. Adds the full 2*DATA_WIDTH signed product in_dataIn*in_dataW to the accumulator. Increments i. When i=IN_NUM-1, goes to WRITE.
- Accumulator width: 2*DATA_WIDTH+8 bits, signed. It cannot overflow for IN_NUM ≤ 255.
- WRITE: the result is the accumulator arithmetically shifted right by FRACTION_BITS (truncation toward −inf), then reduced to DATA_WIDTH per Configuration.
  - Drives out_adrOut=o, out_dataOut=result, out_wr=1 for one cycle.
  - If o=OUT_NUM-1, goes to DONE. Otherwise increments o, clears i and goes to BIAS.
- DONE: asserts axisif_out_done for one cycle, then returns to IDLE.
- axisif_in_start outside IDLE is ignored.
- out_dataOut and out_adrOut hold their last written values until the next write or reset.

## Timing
- Reset value of every output is 0: axisif_out_done, out_wr, out_adrIn, out_adrW, out_adrB, out_adrOut, out_dataOut.
- Each neuron takes IN_NUM+2 cycles: 1 BIAS, IN_NUM MAC, 1 WRITE.
- Start is sampled at edge E0. The first out_wr is high during cycle IN_NUM+2 after E0. At defaults that is the 66th cycle.
- axisif_out_done is high OUT_NUM*(IN_NUM+2)+1 cycles after E0, which is 661 at defaults. It is low again on the following cycle.
- The earliest accepted restart is in the cycle after done.
- Reset mid-operation: on the next edge the FSM goes to IDLE and all outputs return to 0. No further out_wr pulses and no done pulse occur.
- Reset and start high at the same edge: reset wins, and the block stays in IDLE.

## Configuration
- FULLY_CONNECTED_SATURATE_EN defined: a shifted result above the DATA_WIDTH signed range clamps to 0x7FFFFFFF. A result below the range clamps to 0x80000000 (32-bit values shown).
- Macro undefined: the result is the low DATA_WIDTH bits of the shifted accumulator, i.e. two's-complement wrap.

## Test plan
- All x=0, bias[o]=o<<20: out_wr pulses at out_adrOut 0..9 with out_dataOut=o<<20. Done pulses 661 cycles after start.
- All x=1.0 (0x00100000), all w=1.0, bias=0: every output is 64.0 = 0x04000000.
- All x=-2.0, all w=0.5, all bias=+1.0: every output is -63.0 = 0xFC100000.
- All x=w=1000.0, bias=0: with FULLY_CONNECTED_SATURATE_EN every output is 0x7FFFFFFF. Without the macro every output equals the low 32 bits of (64e6<<20).
- rst_n low for one edge, 100 cycles after start: outputs are 0 at the next edge, with no out_wr and no done afterwards. A new start then completes normally with 10 writes.
- axisif_in_start re-pulsed at cycles 5 and 300 of a run: exactly 10 writes and a single done pulse at cycle 661.
